// File: rtl/bcd_counter_n.sv
// N-digit cascadable BCD up/down counter with load, carry-in and wrap/saturate.
// Optional compare output is built when BCD_COUNTER_N_CMP_EN is defined.
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter int SAT    = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  CIN,
    input  logic                  LOAD,
    input  logic                  UP,
    input  logic [4*DIGITS-1:0]   DATA,
`ifdef BCD_COUNTER_N_CMP_EN
    input  logic [4*DIGITS-1:0]   CMP,
    output logic                  MATCH,
`endif
    output logic [4*DIGITS-1:0]   DOUT,
    output logic                  COUT,
    output logic                  WRAP
);

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic [4*DIGITS-1:0] load_val, step_val;
    logic                wrap_q, wrap_d;
    logic                all9, all0, bound;
    logic                ld_fire, st_fire;

    // Boundary detection on the current count
    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_q[4*k +: 4] != 4'd9) all9 = 1'b0;
            if (cnt_q[4*k +: 4] != 4'd0) all0 = 1'b0;
        end
        bound = UP ? all9 : all0;
    end

    // Sanitised load value and rippled step value
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        load_val = '0;
        step_val = cnt_q;
        carry    = 1'b1;
        dig      = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = DATA[4*k +: 4];
            load_val[4*k +: 4] = (dig > 4'd9) ? 4'd9 : dig;
            dig = cnt_q[4*k +: 4];
            if (carry) begin
                if (UP) begin
                    if (dig == 4'd9) begin
                        dig = 4'd0;
                    end else begin
                        dig   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = 4'd9;
                    end else begin
                        dig   = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            step_val[4*k +: 4] = dig;
        end
    end

    // Next-state selection: load beats count; saturation holds at the boundary
    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        ld_fire = 1'b0;
        st_fire = 1'b0;
        if (EN && !LOAD) begin
            cnt_d   = load_val;
            ld_fire = 1'b1;
        end else if (EN && CIN) begin
            if (!(bound && (SAT != 0))) begin
                cnt_d   = step_val;
                wrap_d  = bound;
                st_fire = 1'b1;
            end
        end
    end

    // Count and wrap registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign DOUT = cnt_q;
    assign WRAP = wrap_q;
    assign COUT = bound;

`ifdef BCD_COUNTER_N_CMP_EN
    logic match_q, match_d;

    // Match fires only on an edge that actually loads or steps
    always_comb begin
        match_d = 1'b0;
        if (ld_fire || st_fire) match_d = (cnt_d == CMP);
    end

    // Match pulse register
    always_ff @(posedge CLK) begin
        if (RST) match_q <= 1'b0;
        else     match_q <= match_d;
    end

    assign MATCH = match_q;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: reset, load clamp, wrap, saturate,
// cascade and (with BCD_COUNTER_N_CMP_EN) the compare pulse.
module tb_bcd_counter_n;

    logic       clk = 1'b0;
    logic       rst, en, cin, load, up;
    logic [7:0] data;
    logic [7:0] d0, d1;
    logic       c0, c1, w0, w1;

    logic       c_en, c_load, c_up;
    logic [3:0] lo_data, hi_data, lo_q, hi_q;
    logic       lo_c, hi_c, lo_w, hi_w;

    int errors = 0;
    int checks = 0;

`ifdef BCD_COUNTER_N_CMP_EN
    logic [7:0] cmp;
    logic       m0, m1, lo_m, hi_m;
`endif

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2), .SAT(0)) u_wrap (
        .CLK(clk), .RST(rst), .EN(en), .CIN(cin), .LOAD(load), .UP(up),
        .DATA(data),
`ifdef BCD_COUNTER_N_CMP_EN
        .CMP(cmp), .MATCH(m0),
`endif
        .DOUT(d0), .COUT(c0), .WRAP(w0)
    );

    bcd_counter_n #(.DIGITS(2), .SAT(1)) u_sat (
        .CLK(clk), .RST(rst), .EN(en), .CIN(cin), .LOAD(load), .UP(up),
        .DATA(data),
`ifdef BCD_COUNTER_N_CMP_EN
        .CMP(cmp), .MATCH(m1),
`endif
        .DOUT(d1), .COUT(c1), .WRAP(w1)
    );

    bcd_counter_n #(.DIGITS(1), .SAT(0)) u_lo (
        .CLK(clk), .RST(rst), .EN(c_en), .CIN(1'b1), .LOAD(c_load),
        .UP(c_up), .DATA(lo_data),
`ifdef BCD_COUNTER_N_CMP_EN
        .CMP(4'd0), .MATCH(lo_m),
`endif
        .DOUT(lo_q), .COUT(lo_c), .WRAP(lo_w)
    );

    bcd_counter_n #(.DIGITS(1), .SAT(0)) u_hi (
        .CLK(clk), .RST(rst), .EN(c_en), .CIN(lo_c), .LOAD(c_load),
        .UP(c_up), .DATA(hi_data),
`ifdef BCD_COUNTER_N_CMP_EN
        .CMP(4'd0), .MATCH(hi_m),
`endif
        .DOUT(hi_q), .COUT(hi_c), .WRAP(hi_w)
    );

    // Digit registers must never leave the BCD range
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (d0[3:0] <= 4'd9 && d0[7:4] <= 4'd9);
            assert (d1[3:0] <= 4'd9 && d1[7:4] <= 4'd9);
            assert (lo_q <= 4'd9 && hi_q <= 4'd9);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cin = 1'b1; load = 1'b1; up = 1'b1;
        data = 8'h00;
        c_en = 1'b0; c_load = 1'b1; c_up = 1'b0;
        lo_data = 4'd0; hi_data = 4'd0;
`ifdef BCD_COUNTER_N_CMP_EN
        cmp = 8'h05;
`endif
        // Initial reset
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Load 37, then reset while a load is also requested
        en = 1'b1; load = 1'b0; data = 8'h37;
        tick();
        chk("load37", d0, 8'h37);
        rst = 1'b1; data = 8'h55;
        tick();
        rst = 1'b0;
        chk("rst_dout", d0, 8'h00);
        chk("rst_wrap", w0, 1'b0);
        up = 1'b1; #1;
        chk("rst_cout_up", c0, 1'b0);
        up = 1'b0; #1;
        chk("rst_cout_dn", c0, 1'b1);
        up = 1'b1;

        // Load clamp of an out-of-range digit
        en = 1'b1; load = 1'b0; data = 8'h4C;
        tick();
        chk("clamp", d0, 8'h49);
        chk("clamp_wrap", w0, 1'b0);
        en = 1'b0; load = 1'b0; data = 8'h12;
        tick();
        chk("no_load_en0", d0, 8'h49);

        // Up wrap from 98 (u_sat sees same stimulus and saturates)
        en = 1'b1; load = 1'b0; data = 8'h98;
        tick();
        chk("load98", d0, 8'h98);
        load = 1'b1; cin = 1'b1;
        tick();
        chk("up99", d0, 8'h99);
        chk("up99_cout", c0, 1'b1);
        chk("up99_wrap", w0, 1'b0);
        tick();
        chk("upwrap_dout", d0, 8'h00);
        chk("upwrap_wrap", w0, 1'b1);
        chk("sat_hold99", d1, 8'h99);
        chk("sat_nowrap", w1, 1'b0);
        en = 1'b0;
        tick();
        chk("wrap_onecyc", w0, 1'b0);
        chk("hold00", d0, 8'h00);

        // CIN low blocks the step
        en = 1'b1; cin = 1'b0;
        tick();
        chk("cin0_hold", d0, 8'h00);
        cin = 1'b1;

        // Down wrap from 00
        up = 1'b0;
        tick();
        chk("dnwrap_dout", d0, 8'h99);
        chk("dnwrap_wrap", w0, 1'b1);

        // Saturate down from 01
        load = 1'b0; data = 8'h01;
        tick();
        chk("sat_load01", d1, 8'h01);
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_dn%0d", i), d1, 8'h00);
            chk($sformatf("sat_dn_wrap%0d", i), w1, 1'b0);
        end
        chk("sat_cout", c1, 1'b1);
        chk("wrap_dn_mid", d0, 8'h98);

        // Cascaded single digits: 10 -> 09 -> 08
        en = 1'b0;
        c_en = 1'b1; c_load = 1'b0; c_up = 1'b0;
        lo_data = 4'd0; hi_data = 4'd1;
        tick();
        chk("cas_load", {hi_q, lo_q}, 8'h10);
        chk("cas_lo_cout", lo_c, 1'b1);
        c_load = 1'b1;
        tick();
        chk("cas_09", {hi_q, lo_q}, 8'h09);
        tick();
        chk("cas_08", {hi_q, lo_q}, 8'h08);
        c_en = 1'b0;

`ifdef BCD_COUNTER_N_CMP_EN
        // Compare pulse while counting up from 00
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("m_rst", m0, 1'b0);
        en = 1'b1; cin = 1'b1; load = 1'b1; up = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) en = 1'b0;
            tick();
            chk($sformatf("match%0d", i), m0, (i == 5) ? 1'b1 : 1'b0);
        end
        chk("match_hold_dout", d0, 8'h05);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
